// File: rtl/io_map_pkg.sv
// Shared register map, button indices and FSM encodings for the I/O poll master.
package io_map_pkg;

  localparam logic [7:0] OFS_SW    = 8'h00;
  localparam logic [7:0] OFS_BTN   = 8'h02;
  localparam logic [7:0] OFS_LED   = 8'h10;
  localparam logic [7:0] OFS_DISP0 = 8'h20;
  localparam logic [7:0] OFS_DCTRL = 8'h24;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;

  typedef enum logic [3:0] {
    IDLE, RD_SW, RD_BTN, UPDATE, WR_LED, WR_D0, WR_D1, WR_D2, WR_D3, WR_CTRL
  } state_t;

  typedef enum logic {MODE_COUNT, MODE_SWITCH} mode_t;

  // Digit 0 is the leftmost nibble, so digit n comes from v[15-4n:12-4n].
  function automatic logic [15:0] hex_digit(input logic [15:0] v, input logic [1:0] n);
    logic [15:0] sh;
    sh = v >> (4'd12 - {n, 2'b00});
    return {12'h000, sh[3:0]};
  endfunction

endpackage

// File: rtl/io_poll_master_poll_timer.sv
// Free-running 0..PERIOD-1 counter; tick is high for the cycle at the terminal value.
module poll_timer #(
  parameter int PERIOD = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/io_poll_master.sv
// Stand-alone bus initiator: polls switches/buttons, runs an up/down counter and
// refreshes LEDs and the four-digit display through the basic I/O register map.
module io_poll_master
  import io_map_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          POLL_PERIOD = 100000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] addr,
  output logic [15:0] data_out,
  input  logic [15:0] data_in,
  output logic        we,
  output logic        busy,
  output logic [15:0] count
);

  logic        tick;
  state_t      state_q;
  mode_t       mode_q, mode_d;
  logic [15:0] sw_q, count_q, count_d, shown;
  logic [15:0] addr_q, data_q;
  logic [4:0]  btn_q, btn_prev_q, rise;
  logic        we_q, busy_q;

  poll_timer #(.PERIOD(POLL_PERIOD)) u_timer (
    .clk_i  (clk),
    .rst_i  (reset),
    .tick_o (tick)
  );

  function automatic logic [15:0] reg_addr(input logic [7:0] ofs);
    return {BASE_ADDR[15:8], ofs};
  endfunction

  always_comb begin
    rise    = btn_q & ~btn_prev_q;
    count_d = count_q;
    mode_d  = mode_q;
    if (rise[BTN_C]) begin
      count_d = 16'h0000;
    end else if (rise[BTN_U] && rise[BTN_D]) begin
      count_d = count_q;
    end else if (rise[BTN_U]) begin
      count_d = count_q + 16'h0001;
    end else if (rise[BTN_D]) begin
      count_d = count_q - 16'h0001;
    end
    if (rise[BTN_L]) begin
      mode_d = MODE_COUNT;
    end else if (rise[BTN_R]) begin
      mode_d = MODE_SWITCH;
    end
    shown = (mode_q == MODE_COUNT) ? count_q : sw_q;
  end

  // Each state sets up the bus outputs for the state it hands over to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= MODE_COUNT;
      sw_q       <= '0;
      btn_q      <= '0;
      btn_prev_q <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          we_q <= 1'b0;
          if (tick) begin
            state_q <= RD_SW;
            busy_q  <= 1'b1;
            addr_q  <= reg_addr(OFS_SW);
          end
        end
        RD_SW: begin
          sw_q    <= data_in;
          addr_q  <= reg_addr(OFS_BTN);
          state_q <= RD_BTN;
        end
        RD_BTN: begin
          btn_q   <= data_in[4:0];
          state_q <= UPDATE;
        end
        UPDATE: begin
          btn_prev_q <= btn_q;
          count_q    <= count_d;
          mode_q     <= mode_d;
          addr_q     <= reg_addr(OFS_LED);
          data_q     <= sw_q;
          we_q       <= 1'b1;
          state_q    <= WR_LED;
        end
        WR_LED: begin
          addr_q  <= reg_addr(OFS_DISP0);
          data_q  <= hex_digit(shown, 2'd0);
          state_q <= WR_D0;
        end
        WR_D0: begin
          addr_q  <= reg_addr(OFS_DISP0 + 8'd1);
          data_q  <= hex_digit(shown, 2'd1);
          state_q <= WR_D1;
        end
        WR_D1: begin
          addr_q  <= reg_addr(OFS_DISP0 + 8'd2);
          data_q  <= hex_digit(shown, 2'd2);
          state_q <= WR_D2;
        end
        WR_D2: begin
          addr_q  <= reg_addr(OFS_DISP0 + 8'd3);
          data_q  <= hex_digit(shown, 2'd3);
          state_q <= WR_D3;
        end
        WR_D3: begin
          addr_q  <= reg_addr(OFS_DCTRL);
          data_q  <= 16'h0000;
          state_q <= WR_CTRL;
        end
        WR_CTRL: begin
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign addr     = addr_q;
  assign data_out = data_q;
  assign we       = we_q;
  assign busy     = busy_q;
  assign count    = count_q;

endmodule

// File: tb/tb_io_poll_master.sv
// Bench for io_poll_master: an I/O block model answers reads, and a poll-level
// reference model predicts the counter, mode and the full bus pattern of every poll.
module tb_io_poll_master;

  localparam int          PERIOD = 16;
  localparam logic [15:0] BASE   = 16'h4200;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr, data_out, data_in, count;
  logic        we, busy;

  logic [15:0] sw_v;
  logic [4:0]  btn_v;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int   m_count;
  logic [4:0] m_prev;
  bit   m_switch;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    data_in = 16'hDEAD;
    if (addr[7:0] == 8'h00) data_in = sw_v;
    else if (addr[7:0] == 8'h02) data_in = {11'b0, btn_v};
  end

  io_poll_master #(.BASE_ADDR(BASE), .POLL_PERIOD(PERIOD)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .data_out (data_out),
    .data_in  (data_in),
    .we       (we),
    .busy     (busy),
    .count    (count)
  );

  function automatic void model_reset();
    m_count  = 0;
    m_prev   = 5'b0;
    m_switch = 1'b0;
  endfunction

  function automatic void model_poll(input logic [4:0] b);
    logic [4:0] r;
    r = b & ~m_prev;
    m_prev = b;
    if (r[0]) m_count = 0;
    else if (r[1] && r[4]) m_count = m_count;
    else if (r[1]) m_count = (m_count + 1) % 65536;
    else if (r[4]) m_count = (m_count + 65535) % 65536;
    if (r[2]) m_switch = 1'b0;
    else if (r[3]) m_switch = 1'b1;
  endfunction

  // One full poll: present inputs, wait for busy, then walk all nine active cycles.
  task automatic run_poll(input logic [15:0] sw, input logic [4:0] b, input string tag,
                          output int rise_cyc);
    int n, v, pulses;
    logic [15:0] ea, ed;
    logic ew;
    sw_v = sw;
    btn_v = b;
    model_poll(b);
    v = m_switch ? int'(sw) : m_count;
    n = 0;
    while (busy !== 1'b1 && n < 3 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    rise_cyc = cyc;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_timeout: busy=%b after %0d cycles, required 1", tag, busy, n);
      return;
    end
    pulses = 0;
    for (int k = 0; k < 9; k++) begin
      ed = 16'h0;
      ew = (k >= 3);
      case (k)
        0: ea = BASE | 16'h00;
        1: ea = BASE | 16'h02;
        2: ea = addr;
        3: begin ea = BASE | 16'h10; ed = sw; end
        8: begin ea = BASE | 16'h24; ed = 16'h0; end
        default: begin
          ea = BASE | 16'(16'h20 + k - 4);
          ed = 16'((v / (1 << (4 * (7 - k)))) % 16);
        end
      endcase
      if (we === 1'b1) pulses++;
      checks++;
      if (busy !== 1'b1 || we !== ew || addr !== ea || (ew && data_out !== ed)) begin
        errors++;
        $display("FAIL %s cycle%0d: busy=%b we=%b addr=%h data=%h, required busy=1 we=%b addr=%h data=%h",
                 tag, k, busy, we, addr, data_out, ew, ea, ed);
      end
      if (k == 3) begin
        checks++;
        if (count !== 16'(m_count)) begin
          errors++;
          $display("FAIL %s count: got %h, required %h", tag, count, 16'(m_count));
        end
      end
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0 || we !== 1'b0 || pulses != 6) begin
      errors++;
      $display("FAIL %s end_of_poll: busy=%b we=%b pulses=%0d, required 0 0 6", tag, busy, we, pulses);
    end
  endtask

  task automatic test_reset();
    int r0, r1;
    reset = 1'b1;
    sw_v = 16'hA5C3;
    btn_v = 5'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (addr !== 16'h0 || data_out !== 16'h0 || we !== 1'b0 || busy !== 1'b0 || count !== 16'h0) begin
      errors++;
      $display("FAIL reset_values: addr=%h data=%h we=%b busy=%b count=%h, required all zero",
               addr, data_out, we, busy, count);
    end
    reset = 1'b0;
    r0 = cyc;
    run_poll(16'hA5C3, 5'b0, "first_poll", r1);
    checks++;
    if (r1 - r0 != PERIOD) begin
      errors++;
      $display("FAIL first_tick_delay: got %0d cycles, required %0d", r1 - r0, PERIOD);
    end
    run_poll(16'hA5C3, 5'b0, "second_poll", r0);
    checks++;
    if (r0 - r1 != PERIOD) begin
      errors++;
      $display("FAIL poll_period: got %0d cycles, required %0d", r0 - r1, PERIOD);
    end
  endtask

  task automatic test_up_press();
    int t;
    for (int i = 0; i < 3; i++) run_poll(16'h0F0F, 5'b00010, "up_held", t);
    run_poll(16'h0F0F, 5'b00000, "up_release", t);
    run_poll(16'h0F0F, 5'b00010, "up_repress", t);
    checks++;
    if (count !== 16'h0002) begin
      errors++;
      $display("FAIL up_count: got %h, required 0002", count);
    end
  endtask

  task automatic test_down_wrap();
    int t;
    run_poll(16'h0, 5'b00001, "clear", t);
    run_poll(16'h0, 5'b00000, "clear_release", t);
    run_poll(16'h0, 5'b10000, "down_wrap", t);
    checks++;
    if (count !== 16'hFFFF) begin
      errors++;
      $display("FAIL down_wrap_count: got %h, required FFFF", count);
    end
    run_poll(16'h0, 5'b00000, "down_release", t);
    run_poll(16'h0, 5'b00010, "up_wrap", t);
    checks++;
    if (count !== 16'h0000) begin
      errors++;
      $display("FAIL up_wrap_count: got %h, required 0000", count);
    end
  endtask

  task automatic test_simultaneous();
    int t;
    run_poll(16'h0, 5'b00000, "sim_idle", t);
    run_poll(16'h0, 5'b00010, "sim_up", t);
    run_poll(16'h0, 5'b00000, "sim_idle2", t);
    run_poll(16'h0, 5'b10010, "up_and_down", t);
    run_poll(16'h0, 5'b00000, "sim_idle3", t);
    run_poll(16'h0, 5'b00011, "clear_and_up", t);
    run_poll(16'h0, 5'b00000, "sim_idle4", t);
  endtask

  task automatic test_mode();
    int t;
    run_poll(16'h1234, 5'b00010, "mode_up", t);
    run_poll(16'h1234, 5'b01000, "mode_switch", t);
    run_poll(16'h1234, 5'b00000, "mode_hold", t);
    run_poll(16'h1234, 5'b01100, "mode_l_wins", t);
    run_poll(16'h1234, 5'b00000, "mode_count", t);
  endtask

  task automatic test_random();
    int t;
    for (int i = 0; i < 24; i++)
      run_poll(16'($urandom), 5'($urandom), $sformatf("random%0d", i), t);
  endtask

  task automatic test_mid_reset();
    int n, r0, r1;
    n = 0;
    while (busy !== 1'b1 && n < 3 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (we !== 1'b0 || busy !== 1'b0 || count !== 16'h0 || addr !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset_async: we=%b busy=%b count=%h addr=%h, required 0 0 0000 0000",
               we, busy, count, addr);
    end
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    r0 = cyc;
    run_poll(16'hBEEF, 5'b00000, "after_reset", r1);
    checks++;
    if (r1 - r0 != PERIOD) begin
      errors++;
      $display("FAIL restart_delay: got %0d cycles, required %0d", r1 - r0, PERIOD);
    end
    run_poll(16'hBEEF, 5'b10000, "after_reset_down", r1);
  endtask

  initial begin
    reset = 1'b1;
    sw_v = 16'h0;
    btn_v = 5'b0;
    @(negedge clk);
    test_reset();
    test_up_press();
    test_down_wrap();
    test_simultaneous();
    test_mode();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
